// File: rtl/mem_access_pkg.sv
// Purpose: shared types and constants for the data-memory access unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_BUS     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Purpose: counts bus-request cycles and flags when the wait budget is used up.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts while enable is high, clear has priority.
// Ports: clk, reset (async active-low), clear, enable in; expired out.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: turns the datapath's single-cycle load/store into a handshaked bus transaction.
// Latency: 3 cycles (IDLE, REQ, DONE) with ack on the first REQ cycle, +1 per wait cycle.
// Backpressure: stall holds the core while a request is pending or in flight; TIMEOUT bounds the wait.
// Ports: core side mem_read/mem_write/addr/wdata in, rdata/stall out;
//        bus side bus_req/bus_we/bus_addr/bus_wdata out, bus_ack/bus_rdata/bus_err in;
//        error side err/err_code out, err_clr in.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              err_clr
);

    state_e state_q, state_d;

    logic              req;
    logic              aligned;
    logic              expired;

    logic [31:0]       rdata_q, rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-3:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              err_new;
    logic [1:0]        err_new_code;

    assign req     = mem_read | mem_write;
    assign aligned = (addr[1:0] == 2'b00);

    // Counter runs only while a request is outstanding and restarts from 0 on each entry to REQ.
    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != REQ),
        .enable  (state_q == REQ),
        .expired (expired)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // Misaligned requests skip the bus and go straight to DONE.
                if (req) begin
                    state_d = aligned ? REQ : DONE;
                end
            end
            REQ: begin
                if (bus_ack || expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The request of the instruction just committed is still visible here; drop it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            IDLE:    stall = req;
            REQ:     stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        rdata_d      = rdata_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        err_new      = 1'b0;
        err_new_code = ERR_NONE;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        err_new      = 1'b1;
                        err_new_code = ERR_ALIGN;
                    end else begin
                        // A simultaneous read+write request is issued as a write.
                        bus_we_d    = mem_write;
                        bus_addr_d  = addr[ADDR_W-1:2];
                        bus_wdata_d = wdata;
                        bus_req_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (bus_err) begin
                        err_new      = 1'b1;
                        err_new_code = ERR_BUS;
                    end else if (!bus_we_q) begin
                        rdata_d = bus_rdata;
                    end
                end else if (expired) begin
                    bus_req_d    = 1'b0;
                    err_new      = 1'b1;
                    err_new_code = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // First error is kept until cleared; a new error in the clear cycle takes the slot.
    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        if (err_new && (!err_q || err_clr)) begin
            err_d      = 1'b1;
            err_code_d = err_new_code;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: directed, table-driven bench for mem_access_unit with a small bus responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        err;
    logic [1:0]  err_code;
    logic        err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(
        .ADDR_W  (8),
        .TIMEOUT (16),
        .TO_W    (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err),
        .err       (err),
        .err_code  (err_code),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;      // wait cycles before ack; -1 = never ack
        logic        berr;
        logic [31:0] brdata;
        logic        clr_before; // one-cycle err_clr pulse before the access
        logic        hold_clr;   // err_clr held high for the whole access
        int          exp_stall;
        int          exp_req;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  stall_cnt;
        int  req_cnt;
        bit  done;
        if (v.clr_before) begin
            @(negedge clk);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            #1;
            chk($sformatf("v%0d clr err", idx), {31'd0, err}, 32'd0);
            chk($sformatf("v%0d clr code", idx), {30'd0, err_code}, 32'd0);
        end
        @(negedge clk);
        mem_read  = v.rd;
        mem_write = v.wr;
        addr      = v.addr;
        wdata     = v.wdata;
        err_clr   = v.hold_clr;
        #1;
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            bus_ack = 1'b0;
            bus_err = 1'b0;
            if (stall) begin
                stall_cnt++;
                if (bus_req) begin
                    req_cnt++;
                    chk($sformatf("v%0d bus_we", idx), {31'd0, bus_we}, {31'd0, v.wr});
                    chk($sformatf("v%0d bus_addr", idx), {26'd0, bus_addr}, {26'd0, v.addr[7:2]});
                    if (v.wr) chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.wdata);
                    if (v.waits >= 0 && req_cnt == v.waits + 1) begin
                        bus_ack   = 1'b1;
                        bus_err   = v.berr;
                        bus_rdata = v.brdata;
                    end
                end
                @(negedge clk);
                #1;
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d stall never released", idx);
        end
        chk($sformatf("v%0d stall cycles", idx), stall_cnt, v.exp_stall);
        chk($sformatf("v%0d req cycles", idx), req_cnt, v.exp_req);
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d err_code", idx), {30'd0, err_code}, {30'd0, v.exp_code});
        mem_read  = 1'b0;
        mem_write = 1'b0;
        err_clr   = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
    endtask

    initial begin
        //              rd wr addr   wdata         waits berr brdata        clrb hold st req rdata         err code
        vecs[0]  = '{1'b1, 1'b0, 8'h14, 32'h0,        0, 1'b0, 32'hCAFE0001, 1'b0, 1'b0,  2,  1, 32'hCAFE0001, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h20, 32'h12345678, 3, 1'b0, 32'h0,        1'b0, 1'b0,  5,  4, 32'hCAFE0001, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'h24, 32'hAAAA5555, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0,  2,  1, 32'hCAFE0001, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 8'h03, 32'h0,        0, 1'b0, 32'h0,        1'b0, 1'b0,  1,  0, 32'hCAFE0001, 1'b1, 2'd1};
        vecs[4]  = '{1'b1, 1'b0, 8'h30, 32'h0,        1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0,  3,  2, 32'hDEADBEEF, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 1'b0, 8'h34, 32'h0,        0, 1'b1, 32'h11111111, 1'b1, 1'b0,  2,  1, 32'hDEADBEEF, 1'b1, 2'd2};
        vecs[6]  = '{1'b0, 1'b1, 8'h38, 32'h5A5A5A5A, 0, 1'b1, 32'h0,        1'b0, 1'b0,  2,  1, 32'hDEADBEEF, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 1'b0, 8'h40, 32'h0,       -1, 1'b0, 32'h0,        1'b1, 1'b0, 17, 16, 32'hDEADBEEF, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 1'b0, 8'h44, 32'h0,        0, 1'b0, 32'h0BADF00D, 1'b1, 1'b0,  2,  1, 32'h0BADF00D, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 8'h42, 32'h0,        0, 1'b0, 32'h0,        1'b0, 1'b0,  1,  0, 32'h0BADF00D, 1'b1, 2'd1};
        vecs[10] = '{1'b1, 1'b0, 8'h50, 32'h0,        0, 1'b1, 32'h22222222, 1'b0, 1'b1,  2,  1, 32'h0BADF00D, 1'b1, 2'd2};

        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 8'h00;
        wdata     = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        bus_err   = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst rdata", rdata, 32'h0);
        chk("rst bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst bus_addr", {26'd0, bus_addr}, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst err_code", {30'd0, err_code}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Ack while idle must not disturb anything.
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack   = 1'b0;
        #1;
        chk("idle ack rdata", rdata, 32'h0BADF00D);
        chk("idle ack bus_req", {31'd0, bus_req}, 32'd0);
        chk("idle ack stall", {31'd0, stall}, 32'd0);

        // Reset in the middle of a request, then a stale ack after release.
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 8'h60;
        @(negedge clk);
        #1;
        chk("mid req bus_req", {31'd0, bus_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid rst bus_req", {31'd0, bus_req}, 32'd0);
        chk("mid rst stall idle+req", {31'd0, stall}, 32'd1);
        mem_read = 1'b0;
        #1;
        chk("mid rst stall", {31'd0, stall}, 32'd0);
        chk("mid rst rdata", rdata, 32'h0);
        chk("mid rst err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h77777777;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("late ack bus_req", {31'd0, bus_req}, 32'd0);
        chk("late ack rdata", rdata, 32'h0);
        chk("late ack stall", {31'd0, stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the single-cycle datapath's data-memory port (ALU_out address, read_data2 write data, MemRead/MemWrite controls) and a slow handshaked data bus.
- Turns the one-cycle combinational memory access into a multi-cycle bus transaction.
- Asserts stall to freeze the PC and register-file write until the access completes.
- Adds alignment checking, bus timeout and a sticky error report.

Parameters:
- ADDR_W, 8, byte-address width from the datapath (ALU_out[ADDR_W-1:0]).
- TIMEOUT, 16, number of REQ-state cycles without bus_ack before aborting; must be ≥2.
- TO_W, 5, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request from control (MemRead).
- mem_write  in  1  store request from control (MemWrite).
- addr  in  ADDR_W  byte address (ALU_out).
- wdata  in  32  store data (read_data2).
- rdata  out  32  load data to the MemToReg mux.
- stall  out  1  core must hold PC and suppress reg_write while high.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  ADDR_W-2  word address, registered.
- bus_wdata  out  32  registered store data.
- bus_ack  in  1  transaction complete; sampled only in REQ.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_err  in  1  slave error, valid with bus_ack.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout; latched with err.
- err_clr  in  1  synchronous clear of err/err_code.

Behaviour:
- Reset (reset low, async): state IDLE; rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, err=0, err_code=0, counter=0.
- stall is combinational: stall = (IDLE & (mem_read|mem_write)) | REQ. It is 0 in DONE and when idle with no request.
- IDLE:
  - If no request, stay.
  - Request with addr[1:0]!=0: no bus cycle; next state DONE; set err=1, err_code=1; rdata keeps its old value.
  - Request with aligned addr: latch bus_we=mem_write, bus_addr=addr[ADDR_W-1:2], bus_wdata=wdata; set bus_req=1; next state REQ; counter=0.
  - mem_read and mem_write both high: treated as a write.
- REQ:
  - bus_req held high; address and data stable.
  - On bus_ack=1: bus_req←0, next state DONE.
    - If a read with bus_err=0: rdata←bus_rdata.
    - If bus_err=1: err←1, err_code←2, rdata unchanged.
  - If no ack and counter==TIMEOUT-1: bus_req←0, err←1, err_code←3, next state DONE.
  - Otherwise counter increments.
- DONE:
  - One cycle; stall=0 so the core commits (PC advances, load data written back); next state IDLE unconditionally.
  - The still-asserted request of the same instruction is ignored.
- Latency:
  - Aligned access with ack in the first REQ cycle: 3 cycles (IDLE, REQ, DONE), stall high for 2.
  - Each extra wait cycle adds 1.
- Error register:
  - The first error wins; later errors do not overwrite err_code while err=1.
  - err_clr in the same cycle as a new error: the new error wins.
- bus_ack outside REQ is ignored. Reset mid-REQ drops bus_req immediately, and a late ack is ignored.
- rdata holds its value between loads; stores never modify it.

Decomposition:
- Package mem_access_pkg:
  - state enum IDLE/REQ/DONE.
  - err_code constants ERR_NONE, ERR_ALIGN, ERR_BUS, ERR_TIMEOUT.
- Sub-module mem_timeout_cnt:
  - Inputs: clk, reset, clear, enable.
  - Output: expired when count==TIMEOUT-1.
  - Parameterised by TIMEOUT and TO_W.

Test Plan:
- Aligned read, addr=8'h14, bus_ack on 1st REQ cycle with bus_rdata=32'hCAFE0001 -> bus_addr=6'h05, bus_we=0, stall high exactly 2 cycles, rdata=32'hCAFE0001 in DONE, err=0.
- Write, addr=8'h20, wdata=32'h12345678, ack after 3 wait cycles -> bus_we=1, bus_wdata=32'h12345678 stable across all REQ cycles, stall high 5 cycles, rdata unchanged.
- Misaligned read, addr=8'h03 -> no bus_req ever, stall high 1 cycle, err=1, err_code=1.
- No ack, TIMEOUT=16 -> bus_req high exactly 16 cycles, then DONE with err_code=3. A following access still works.
- bus_ack with bus_err=1, then second access with bus_err=1 and err_clr pulsed in between -> err_code=2 after each. Without err_clr, the first code is retained.
- reset low mid-REQ, then bus_ack pulsed after reset release -> bus_req=0 immediately, state IDLE, ack ignored, rdata=0.
